root_req_sequencer: RTL and testbench
=====================================

ROOT_REQ_SEQUENCER -- requirements
Module: root_req_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, request FIFO entries; SHALL be a power of two, 2..8.
REQ-002 Parameter ISSUE_CYCLES, default 2, number of cycles core_in_valid SHALL stay high per request.
REQ-003 Parameter TIMEOUT_CYC, default 63, WAIT-state cycle limit; only used under REQ-024.
REQ-004 Ports SHALL be:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request offered.
- req_base  in  10  radicand, unsigned integer.
- req_exp  in  3  root degree.
- req_ready  out  1  FIFO can accept a request.
- core_in_valid  out  1  valid to the root core.
- core_in_data_1  out  10  radicand to the core.
- core_in_data_2  out  3  degree to the core.
- core_out_valid  in  1  core result valid.
- core_out_data  in  20  core result, Q10.10.
- res_valid  out  1  result presented.
- res_data  out  20  result, Q10.10.
- res_err  out  1  result invalid (degree 0 or timeout).
- res_ready  in  1  consumer accepts result.
- fifo_level  out  4  current FIFO occupancy.

Function
REQ-005 req_ready SHALL be 1 exactly when fifo_level < FIFO_DEPTH; it is derived only from registered state.
REQ-006 Push SHALL occur on req_valid && req_ready; req_valid while full SHALL be ignored with no state change.
REQ-007 Simultaneous push and pop SHALL leave fifo_level unchanged and preserve FIFO order; read/write pointers wrap modulo FIFO_DEPTH.
REQ-008 FSM states SHALL be IDLE, ISSUE, WAIT, DRAIN, RESP.
REQ-009 IDLE: if fifo_level > 0, pop the head into operand registers the same cycle; if popped req_exp == 0, go to RESP with res_err=1 and res_data=0, without issuing to the core; otherwise go to ISSUE. If empty, stay in IDLE.
REQ-010 ISSUE: core_in_valid=1 for exactly ISSUE_CYCLES consecutive cycles, then go to WAIT.
REQ-011 core_in_data_1/core_in_data_2 SHALL hold the popped operands from ISSUE entry until DRAIN exits; they are 0 in IDLE.
REQ-012 WAIT: core_in_valid=0; on the first cycle with core_out_valid=1, capture core_out_data into res_data, set res_err=0, and go to DRAIN.
REQ-013 DRAIN: remain until core_out_valid==0, then go to RESP; this guarantees the core has returned to its idle state before the next issue.
REQ-014 RESP: res_valid=1 with res_data and res_err stable until the cycle res_ready=1; then res_valid deasserts on the next edge and the FSM returns to IDLE.
REQ-015 Minimum request-to-request spacing SHALL be 1 IDLE cycle after RESP; no back-to-back issue without passing IDLE.
REQ-016 core_out_valid outside WAIT/DRAIN SHALL be ignored.
REQ-017 All outputs except req_ready SHALL be registered.
REQ-018 FIFO pushes SHALL continue in every FSM state.

Reset
REQ-019 rst_n=0 at a clock edge SHALL reset the state to IDLE, FIFO pointers and fifo_level to 0, and operand registers to 0.
REQ-020 Reset values SHALL be: core_in_valid=0, core_in_data_1=0, core_in_data_2=0, res_valid=0, res_data=0, res_err=0; req_ready SHALL be 1 in the cycle after reset.
REQ-021 Reset mid-operation (any state) SHALL discard the in-flight request and all queued requests; no res_valid for them.
REQ-022 Reset SHALL not depend on core_out_valid; a stale core pulse after reset is ignored per REQ-016.

Configuration
REQ-023 Macro ROOT_SEQ_TIMEOUT_EN SHALL select the WAIT timeout.
REQ-024 Defined: a counter SHALL clear on WAIT entry and increment each WAIT cycle; at TIMEOUT_CYC cycles without core_out_valid, go to RESP with res_err=1 and res_data=0.
REQ-025 Not defined: no counter SHALL be present, and WAIT SHALL last until core_out_valid indefinitely.

Verification
REQ-026 Request base=16, exp=2, res_ready=1, core model returns 0x01000 → res_valid once, res_data=0x01000, res_err=0; core_in_valid high exactly 2 cycles.
REQ-027 Request base=27, exp=0 → res_valid, res_err=1, res_data=0; core_in_valid never asserted.
REQ-028 Push 5 requests back-to-back with core stalled → 4 accepted, req_ready=0, fifo_level=4; results emerge in push order.
REQ-029 Core holds core_out_valid high 2 cycles → one result only; next core_in_valid rises no earlier than 2 cycles after core_out_valid falls.
REQ-030 res_ready held 0 for 10 cycles in RESP → res_data/res_err stable, no new issue; with ROOT_SEQ_TIMEOUT_EN defined and core silent → res_err=1 after 63 WAIT cycles.
REQ-031 rst_n=0 for 1 cycle during WAIT with 2 requests queued → fifo_level=0, all outputs at reset values, no res_valid afterward.

Source files
------------

// File: rtl/root_req_sequencer.sv
// root_req_sequencer: request FIFO that feeds a root core one operation at a time via an IDLE/ISSUE/WAIT/DRAIN/RESP FSM.
// Define ROOT_SEQ_TIMEOUT_EN to bound WAIT to TIMEOUT_CYC cycles; expiry returns an error result.
module root_req_sequencer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int ISSUE_CYCLES = 2,
  parameter int TIMEOUT_CYC  = 63
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [9:0]  req_base,
  input  logic [2:0]  req_exp,
  output logic        req_ready,
  output logic        core_in_valid,
  output logic [9:0]  core_in_data_1,
  output logic [2:0]  core_in_data_2,
  input  logic        core_out_valid,
  input  logic [19:0] core_out_data,
  output logic        res_valid,
  output logic [19:0] res_data,
  output logic        res_err,
  input  logic        res_ready,
  output logic [3:0]  fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int IC_W  = $clog2(ISSUE_CYCLES + 1);

  generate
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 8 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        ISSUE_CYCLES < 1 || TIMEOUT_CYC < 1) begin : g_bad_params
      $error("root_req_sequencer: illegal parameter value");
    end
  endgenerate

  // Handshakes: a request transfers on a rising edge with req_valid && req_ready; a result
  // transfers on a rising edge with res_valid && res_ready, and res_data/res_err stay stable until then.
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, RESP} state_t;
  state_t state;

  logic [12:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [IC_W-1:0]  issue_cnt;
  logic [12:0]      head;
  logic             push;
  logic             pop;

`ifdef ROOT_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] wait_cnt;
`endif

  assign req_ready = fifo_level < 4'(FIFO_DEPTH);
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && (fifo_level != 4'd0);
  assign head      = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {req_base, req_exp};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_level     <= 4'd0;
      issue_cnt      <= '0;
      core_in_valid  <= 1'b0;
      core_in_data_1 <= 10'd0;
      core_in_data_2 <= 3'd0;
      res_valid      <= 1'b0;
      res_data       <= 20'd0;
      res_err        <= 1'b0;
`ifdef ROOT_SEQ_TIMEOUT_EN
      wait_cnt       <= '0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 4'd1;
        2'b01:   fifo_level <= fifo_level - 4'd1;
        default: fifo_level <= fifo_level;
      endcase

      case (state)
        IDLE: begin
          if (pop) begin
            // Degree 0 has no root: answer with an error without involving the core.
            if (head[2:0] == 3'd0) begin
              res_valid <= 1'b1;
              res_err   <= 1'b1;
              res_data  <= 20'd0;
              state     <= RESP;
            end else begin
              core_in_data_1 <= head[12:3];
              core_in_data_2 <= head[2:0];
              core_in_valid  <= 1'b1;
              issue_cnt      <= '0;
              state          <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (issue_cnt == IC_W'(ISSUE_CYCLES - 1)) begin
            core_in_valid <= 1'b0;
`ifdef ROOT_SEQ_TIMEOUT_EN
            wait_cnt      <= '0;
`endif
            state         <= WAIT;
          end else begin
            issue_cnt <= issue_cnt + IC_W'(1);
          end
        end
        WAIT: begin
          if (core_out_valid) begin
            res_data <= core_out_data;
            res_err  <= 1'b0;
            state    <= DRAIN;
          end
`ifdef ROOT_SEQ_TIMEOUT_EN
          else if (wait_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            res_valid      <= 1'b1;
            res_err        <= 1'b1;
            res_data       <= 20'd0;
            core_in_data_1 <= 10'd0;
            core_in_data_2 <= 3'd0;
            state          <= RESP;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
`endif
        end
        DRAIN: begin
          // Leave only once the core has dropped its valid, so it is idle before the next issue.
          if (!core_out_valid) begin
            res_valid      <= 1'b1;
            core_in_data_1 <= 10'd0;
            core_in_data_2 <= 3'd0;
            state          <= RESP;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_root_req_sequencer.sv
// tb_root_req_sequencer: directed + randomized scoreboard bench for root_req_sequencer with a behavioural root core.
// With ROOT_SEQ_TIMEOUT_EN defined it also exercises the WAIT timeout.
module tb_root_req_sequencer;

  localparam int FIFO_DEPTH   = 4;
  localparam int ISSUE_CYCLES = 2;
  localparam int TIMEOUT_CYC  = 63;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [9:0]  req_base = '0;
  logic [2:0]  req_exp = '0;
  logic        req_ready;
  logic        core_in_valid;
  logic [9:0]  core_in_data_1;
  logic [2:0]  core_in_data_2;
  logic        core_out_valid = 1'b0;
  logic [19:0] core_out_data = '0;
  logic        res_valid;
  logic [19:0] res_data;
  logic        res_err;
  logic        res_ready = 1'b1;
  logic [3:0]  fifo_level;

  int total = 0;
  int bad = 0;

  logic [20:0] exp_q[$];
  logic [12:0] issue_q[$];
  logic [12:0] core_job_q[$];

  bit core_stall = 1'b0;
  bit expect_timeout = 1'b0;
  bit rr_rand = 1'b0;
  int core_lat_max = 0;
  int hold_min = 1;
  int hold_max = 1;

  int cyc = 0;
  int last_cov_fall = -100;
  int last_civ_fall = 0;
  int res_rise_cyc = 0;
  int acc_cnt = 0;
  int issued_cnt = 0;
  int civ_len = 0;
  logic civ_prev = 1'b0;
  logic cov_prev = 1'b0;
  logic rv_prev = 1'b0;
  logic [12:0] cur_job = '0;

  root_req_sequencer #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .ISSUE_CYCLES(ISSUE_CYCLES),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_base(req_base),
    .req_exp(req_exp),
    .req_ready(req_ready),
    .core_in_valid(core_in_valid),
    .core_in_data_1(core_in_data_1),
    .core_in_data_2(core_in_data_2),
    .core_out_valid(core_out_valid),
    .core_out_data(core_out_data),
    .res_valid(res_valid),
    .res_data(res_data),
    .res_err(res_err),
    .res_ready(res_ready),
    .fifo_level(fifo_level)
  );

  // clock / reset
  initial forever #5 clk = ~clk;

  // Integer e-th root of b (largest r with r**e <= b), returned in Q10.10.
  function automatic logic [19:0] root_q(input logic [9:0] b, input logic [2:0] e);
    int r;
    longint p;
    r = 0;
    for (int c = 1; c <= 1023; c++) begin
      p = 1;
      for (int k = 0; k < int'(e); k++) if (p <= 1023) p = p * c;
      if (p > longint'(b)) break;
      r = c;
    end
    return 20'(r) << 10;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_civ"}, 32'(core_in_valid), 0);
    check({tag, "_data1"}, 32'(core_in_data_1), 0);
    check({tag, "_data2"}, 32'(core_in_data_2), 0);
    check({tag, "_res_valid"}, 32'(res_valid), 0);
    check({tag, "_res_data"}, 32'(res_data), 0);
    check({tag, "_res_err"}, 32'(res_err), 0);
    check({tag, "_level"}, 32'(fifo_level), 0);
    check({tag, "_req_ready"}, 32'(req_ready), 1);
  endtask

  // driver tasks
  task automatic send_req(input logic [9:0] b, input logic [2:0] e);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_base  = b;
    req_exp   = e;
    @(negedge clk);
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("push_bound", 32'(n < 300), 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_issued(input int target);
    int n;
    n = 0;
    while (issued_cnt < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("issue_bound", 32'(n < 500), 1);
  endtask

  task automatic wait_res(input int limit);
    int n;
    n = 0;
    while (!res_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("res_bound", 32'(n < limit), 1);
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || res_valid) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("drain_bound", 32'(n < limit), 1);
  endtask

  // behavioural root core: answers each completed issue after a latency, valid held hold_min..hold_max cycles
  initial begin
    logic [12:0] job;
    forever begin
      @(posedge clk);
      if (core_job_q.size() > 0) begin
        job = core_job_q.pop_front();
        repeat ($urandom_range(core_lat_max, 0)) @(posedge clk);
        while (core_stall) @(posedge clk);
        #1;
        core_out_valid = 1'b1;
        core_out_data  = root_q(job[12:3], job[2:0]);
        repeat ($urandom_range(hold_max, hold_min)) @(posedge clk);
        #1;
        core_out_valid = 1'b0;
        core_out_data  = 20'($urandom);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rr_rand) res_ready = ($urandom_range(0, 3) != 0);
  end

  // scoreboard: reference model on accepted requests, monitor on issues and results
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      civ_prev = 1'b0;
      cov_prev = 1'b0;
      rv_prev  = 1'b0;
    end else begin
      if (req_valid && req_ready) begin
        acc_cnt++;
        if (req_exp == 3'd0 || expect_timeout) exp_q.push_back({1'b1, 20'd0});
        else exp_q.push_back({1'b0, root_q(req_base, req_exp)});
        if (req_exp != 3'd0) issue_q.push_back({req_base, req_exp});
      end
      if (core_in_valid && !civ_prev) begin
        check("issue_gap", 32'((cyc - last_cov_fall) >= 2), 1);
        check("issue_expected", 32'(issue_q.size() > 0), 1);
        if (issue_q.size() > 0) cur_job = issue_q.pop_front();
        else cur_job = {core_in_data_1, core_in_data_2};
        civ_len = 0;
      end
      if (core_in_valid) begin
        civ_len++;
        check("issue_data", 32'({core_in_data_1, core_in_data_2}), 32'(cur_job));
      end
      if (!core_in_valid && civ_prev) begin
        check("issue_len", civ_len, ISSUE_CYCLES);
        core_job_q.push_back(cur_job);
        issued_cnt++;
        last_civ_fall = cyc;
      end
      if (!core_out_valid && cov_prev) last_cov_fall = cyc;
      if (res_valid && !rv_prev) res_rise_cyc = cyc;
      if (res_valid) begin
        check("res_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          check("res_value", 32'({res_err, res_data}), 32'(exp_q[0]));
          if (res_ready) void'(exp_q.pop_front());
        end
      end
      civ_prev = core_in_valid;
      cov_prev = core_out_valid;
      rv_prev  = res_valid;
    end
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog: got no finish want finish by t=%0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int base_cnt;
    logic [2:0] e;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset("reset");

    // 16 ** (1/2) = 4.0 -> 0x01000
    send_req(10'd16, 3'd2);
    drain(200);
    // degree 0 -> error, no issue
    send_req(10'd27, 3'd0);
    drain(200);

    // core stalled with one request in WAIT: only 4 of 5 pushes fit
    core_stall = 1'b1;
    base_cnt = issued_cnt;
    send_req(10'd100, 3'd3);
    wait_issued(base_cnt + 1);
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_base  = 10'(200 + i * 131);
      req_exp   = 3'(1 + i % 3);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("full_accepted", acc_cnt, 4);
    check("full_level", 32'(fifo_level), 4);
    check("full_ready", 32'(req_ready), 0);
    core_stall = 1'b0;
    drain(2000);

    // core holds valid 2 cycles: one result each, spacing checked by the monitor
    hold_min = 2;
    hold_max = 2;
    send_req(10'd625, 3'd4);
    send_req(10'd343, 3'd3);
    drain(500);
    hold_min = 1;

    // consumer stalls 10 cycles in RESP with another request queued
    res_ready = 1'b0;
    send_req(10'd200, 3'd2);
    send_req(10'd81, 3'd4);
    wait_res(300);
    repeat (10) begin
      @(negedge clk);
      check("stall_res_valid", 32'(res_valid), 1);
      check("stall_no_issue", 32'(core_in_valid), 0);
    end
    check("stall_level", 32'(fifo_level), 1);
    @(posedge clk);
    #1 res_ready = 1'b1;
    drain(500);

`ifdef ROOT_SEQ_TIMEOUT_EN
    core_stall = 1'b1;
    expect_timeout = 1'b1;
    send_req(10'd50, 3'd2);
    expect_timeout = 1'b0;
    wait_res(300);
    @(negedge clk);
    check("timeout_cycles", res_rise_cyc - last_civ_fall, TIMEOUT_CYC);
    check("timeout_err", 32'(res_err), 1);
    drain(100);
    core_stall = 1'b0;
    repeat (20) @(negedge clk);
`endif

    // reset during WAIT with 2 queued requests
    core_stall = 1'b1;
    base_cnt = issued_cnt;
    send_req(10'd100, 3'd2);
    wait_issued(base_cnt + 1);
    send_req(10'd64, 3'd3);
    send_req(10'd9, 3'd2);
    @(negedge clk);
    check("pre_reset_level", 32'(fifo_level), 2);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    issue_q.delete();
    @(negedge clk);
    check_reset("mid_reset");
    core_stall = 1'b0;
    repeat (30) @(negedge clk);
    check("post_reset_quiet", 32'(res_valid), 0);

    // randomized traffic
    rr_rand = 1'b1;
    hold_max = 3;
    core_lat_max = 4;
    for (int i = 0; i < 40; i++) begin
      e = ($urandom_range(0, 5) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      send_req(10'($urandom_range(0, 1023)), e);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    rr_rand = 1'b0;
    @(posedge clk);
    #1 res_ready = 1'b1;
    drain(3000);

    check("final_exp_q", exp_q.size(), 0);
    check("final_issue_q", issue_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
